tlc_phase_scheduler: RTL

Phase scheduler for the two-road signalled intersection: it shares the crossing between the main road (lights 1), the farm road (lights 2, requested by FM) and a latched pedestrian request (PED). It sequences green, yellow, all-red and walk phases on a prescaled tick, with a minimum main-road green and a maximum farm-road green. It drives the six lamp outputs plus WALK and a phase status code. It is the sequencing controller above the light-timing datapath.

---
 rtl/tlc_pkg.sv | 41 ++++
 rtl/tlc_tick_gen.sv | 14 +
 rtl/tlc_phase_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: phase codes, lamp patterns and default timing shared by the intersection controller.
package tlc_pkg;
  typedef enum logic [2:0] {
    G1  = 3'd0,
    Y1  = 3'd1,
    AR1 = 3'd2,
    G2  = 3'd3,
    Y2  = 3'd4,
    AR2 = 3'd5,
    WK  = 3'd6
  } phase_e;
  typedef struct packed {
    logic grn1;
    logic ylw1;
    logic red1;
    logic grn2;
    logic ylw2;
    logic red2;
    logic walk;
  } lamps_t;
  localparam lamps_t L_G1  = lamps_t'(7'b1000010);
  localparam lamps_t L_Y1  = lamps_t'(7'b0100010);
  localparam lamps_t L_AR  = lamps_t'(7'b0010010);
  localparam lamps_t L_G2  = lamps_t'(7'b0011000);
  localparam lamps_t L_Y2  = lamps_t'(7'b0010100);
  localparam lamps_t L_WK  = lamps_t'(7'b0010011);
  localparam int PRE_W_DEF   = 4;
  localparam int TW_DEF      = 4;
  localparam int T_G1MIN_DEF = 12;
  localparam int T_G2MAX_DEF = 8;
  localparam int T_Y_DEF     = 3;
  localparam int T_AR_DEF    = 1;
  localparam int T_WALK_DEF  = 5;
  function automatic lamps_t phase_lamps(input phase_e p);
    return p == G1 ? L_G1 :
           p == Y1 ? L_Y1 :
           p == G2 ? L_G2 :
           p == Y2 ? L_Y2 :
           p == WK ? L_WK : L_AR;
  endfunction
endpackage

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: free-running prescaler that emits one tick per wrap, or every cycle in test mode.
module tlc_tick_gen #(
  parameter int PRE_W = 4
) (
  input  logic ck_i,
  input  logic clrn_i,
  input  logic test_i,
  output logic tick_o
);
  logic [PRE_W-1:0] pre_q, pre_d;
  always_comb pre_d = pre_q + 1'b1;
  always_ff @(posedge ck_i) pre_q <= !clrn_i ? '0 : pre_d;
  assign tick_o = test_i | (&pre_q);
endmodule

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: sequences main/farm/walk phases on prescaled ticks with min/max green limits.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int PRE_W   = PRE_W_DEF,
  parameter int TW      = TW_DEF,
  parameter int T_G1MIN = T_G1MIN_DEF,
  parameter int T_G2MAX = T_G2MAX_DEF,
  parameter int T_Y     = T_Y_DEF,
  parameter int T_AR    = T_AR_DEF,
  parameter int T_WALK  = T_WALK_DEF
) (
  input  logic       CK,
  input  logic       CLRN,
  input  logic       FM,
  input  logic       PED,
  input  logic       TEST,
  output logic       GRN1,
  output logic       YLW1,
  output logic       RED1,
  output logic       GRN2,
  output logic       YLW2,
  output logic       RED2,
  output logic       WALK,
  output logic [2:0] PHASE
);
  localparam int TMAX = (1 << TW) - 1;
  if (T_G1MIN < 1 || T_G1MIN > TMAX || T_G2MAX < 1 || T_G2MAX > TMAX || T_Y < 1 || T_Y > TMAX ||
      T_AR < 1 || T_AR > TMAX || T_WALK < 1 || T_WALK > TMAX) begin : g_bad_timing
    $error("tlc_phase_scheduler: timing parameter out of range for TW");
  end
  localparam logic [TW-1:0] G1_LAST = TW'(T_G1MIN - 1);
  localparam logic [TW-1:0] G2_LAST = TW'(T_G2MAX - 1);
  localparam logic [TW-1:0] Y_LAST  = TW'(T_Y - 1);
  localparam logic [TW-1:0] AR_LAST = TW'(T_AR - 1);
  localparam logic [TW-1:0] WK_LAST = TW'(T_WALK - 1);
  logic          tick;
  logic          fm_s1_q, fms_q, ped_s1_q, peds_q;
  logic          ped_pend_q, ped_pend_d;
  logic          from_main_q, from_main_d;
  phase_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  lamps_t        lamps_q;
  tlc_tick_gen #(.PRE_W(PRE_W)) u_tick (
    .ck_i  (CK),
    .clrn_i(CLRN),
    .test_i(TEST),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        G1:      state_d = (timer_q >= G1_LAST && (fms_q || ped_pend_q)) ? Y1 : G1;
        Y1:      state_d = timer_q == Y_LAST ? AR1 : Y1;
        AR1:     state_d = timer_q == AR_LAST ? (ped_pend_q ? WK : G2) : AR1;
        G2:      state_d = (!fms_q || timer_q == G2_LAST) ? Y2 : G2;
        Y2:      state_d = timer_q == Y_LAST ? AR2 : Y2;
        AR2:     state_d = timer_q == AR_LAST ? (ped_pend_q ? WK : G1) : AR2;
        WK:      state_d = timer_q == WK_LAST ? ((from_main_q && fms_q) ? G2 : G1) : WK;
        default: state_d = G1;
      endcase
    end
  end
  // Requests are swallowed for the whole walk, not just its first cycle.
  always_comb begin
    ped_pend_d  = (state_d == WK || state_q == WK) ? 1'b0 : (ped_pend_q | peds_q);
    from_main_d = (state_d == WK && state_q == AR1) ? 1'b1 :
                  (state_d == WK && state_q == AR2) ? 1'b0 : from_main_q;
    timer_d     = state_d != state_q ? '0 :
                  (tick && timer_q != TW'(TMAX)) ? timer_q + 1'b1 : timer_q;
  end
  always_ff @(posedge CK) begin
    if (!CLRN) begin
      fm_s1_q     <= 1'b0;
      fms_q       <= 1'b0;
      ped_s1_q    <= 1'b0;
      peds_q      <= 1'b0;
      ped_pend_q  <= 1'b0;
      from_main_q <= 1'b0;
      state_q     <= G1;
      timer_q     <= '0;
      lamps_q     <= L_G1;
    end else begin
      fm_s1_q     <= FM;
      fms_q       <= fm_s1_q;
      ped_s1_q    <= PED;
      peds_q      <= ped_s1_q;
      ped_pend_q  <= ped_pend_d;
      from_main_q <= from_main_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      lamps_q     <= phase_lamps(state_d);
    end
  end
  assign GRN1  = lamps_q.grn1;
  assign YLW1  = lamps_q.ylw1;
  assign RED1  = lamps_q.red1;
  assign GRN2  = lamps_q.grn2;
  assign YLW2  = lamps_q.ylw2;
  assign RED2  = lamps_q.red2;
  assign WALK  = lamps_q.walk;
  assign PHASE = state_q;
endmodule
